uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the UART_CAL path. It accepts result bytes from the calculator core over a valid/ready handshake and holds up to FIFO_DEPTH bytes. It serialises them on txd as 8N1 frames by default, with optional parity and a second stop bit. It is the transmit-side counterpart to the existing UART receiver and uses the same bit timing (16 clocks per bit at the 100 MHz bench clock, i.e. 160 ns per bit).

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 50 +++++
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, line levels and default
// bit timing, used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    // Line levels seen on the serial wire
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity bit for a data byte: even parity when odd=0, odd parity when odd=1
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. The head entry is presented
// combinationally on pop_data so a pop can consume it on the same edge.
// A push is accepted while full if a pop happens on the same edge.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_reg;
    logic [AW:0]      rptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (wptr_reg[AW] != rptr_reg[AW]) && (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
    assign empty    = (wptr_reg == rptr_reg);
    assign count    = wptr_reg - rptr_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rptr_reg[AW-1:0]];

    // Pointer update; wrap is handled by the extra MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + 1'b1;
            if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
        end
    end

    // Storage write; contents need no reset because pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_reg[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a small FIFO over valid/ready and
// are serialised as start, 8 data bits LSB first, optional parity and one or
// two stop bits. Frames follow each other with no idle gap while data waits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]                state_reg;
    logic [CW-1:0]             baud_reg;
    logic [2:0]                bit_idx_reg;
    logic [7:0]                shift_reg;
    logic                      parity_reg;
    logic                      stop_idx_reg;
    logic                      txd_reg;
    logic                      ready_en_reg;

    logic [7:0]                head_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_end;
    logic                      stop_last;
    logic                      pop;
    logic                      push;

    assign bit_end   = (baud_reg == CW'(CLKS_PER_BIT - 1));
    assign stop_last = (STOP_BITS == 1) || stop_idx_reg;
    // Pop when idle, or on the final cycle of the last stop bit so the next
    // start bit follows immediately.
    assign pop       = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end && stop_last));
    // Ready is held low until the first edge after reset; a full FIFO still
    // takes a byte on the edge that frees a slot.
    assign tx_ready  = ready_en_reg && (!fifo_full || pop);
    assign push      = tx_valid && tx_ready;
    assign txd       = txd_reg;
    assign tx_busy   = (state_reg != ST_IDLE) || (fifo_count != '0);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (tx_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Frame sequencer: baud counter, bit shifter and registered line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            stop_idx_reg <= 1'b0;
            txd_reg      <= LINE_IDLE;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    baud_reg <= '0;
                    if (pop) begin
                        state_reg  <= ST_START;
                        shift_reg  <= head_data;
                        parity_reg <= parity_bit(head_data, 1'(PARITY_ODD));
                        txd_reg    <= LINE_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                        txd_reg     <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                state_reg <= ST_PARITY;
                                txd_reg   <= parity_reg;
                            end else begin
                                state_reg    <= ST_STOP;
                                stop_idx_reg <= 1'b0;
                                txd_reg      <= LINE_STOP;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            txd_reg     <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_reg     <= '0;
                        state_reg    <= ST_STOP;
                        stop_idx_reg <= 1'b0;
                        txd_reg      <= LINE_STOP;
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_reg <= '0;
                        if (stop_last) begin
                            if (pop) begin
                                state_reg  <= ST_START;
                                shift_reg  <= head_data;
                                parity_reg <= parity_bit(head_data, 1'(PARITY_ODD));
                                txd_reg    <= LINE_START;
                            end else begin
                                state_reg <= ST_IDLE;
                                txd_reg   <= LINE_IDLE;
                            end
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    baud_reg  <= '0;
                    txd_reg   <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E1, 8O2) share one stimulus
// stream; a frame-level reference model predicts txd, ready, busy and count
// every cycle.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int NM    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                tx_valid;
    logic [7:0]          tx_data;
    logic [NM-1:0]       txd_w;
    logic [NM-1:0]       ready_w;
    logic [NM-1:0]       busy_w;
    logic [NM-1:0][2:0]  count_w;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NM; gi++) begin : g_dut
        uart_tx_fifo #(
            .CLKS_PER_BIT (CPB),
            .FIFO_DEPTH   (DEPTH),
            .PARITY_EN    ((gi >= 1) ? 1 : 0),
            .PARITY_ODD   ((gi == 2) ? 1 : 0),
            .STOP_BITS    ((gi == 2) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid),
            .tx_ready   (ready_w[gi]),
            .txd        (txd_w[gi]),
            .tx_busy    (busy_w[gi]),
            .fifo_count (count_w[gi])
        );
    end

    // Reference model: byte queue plus position within the current frame
    int         n_m      [NM];
    int         rd_m     [NM];
    int         pos_m    [NM];
    bit         active_m [NM];
    bit         ren_m    [NM];
    bit         acc_m    [NM];
    logic [7:0] cur_m    [NM];
    logic [7:0] mem_m    [NM][DEPTH];

    function automatic int pen(input int m);  return (m >= 1) ? 1 : 0; endfunction
    function automatic int podd(input int m); return (m == 2) ? 1 : 0; endfunction
    function automatic int sb(input int m);   return (m == 2) ? 2 : 1; endfunction
    function automatic int flen(input int m); return (10 + pen(m) + sb(m) - 1) * CPB; endfunction

    // Line level of bit slot 'slot' in the frame carrying byte b
    function automatic logic frame_level(input int m, input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (pen(m) == 1 && slot == 9) return (^b) ^ (podd(m) == 1);
        return 1'b1;
    endfunction

    function automatic bit pop_pending(input int m);
        return (n_m[m] > 0) && (!active_m[m] || pos_m[m] == flen(m) - 1);
    endfunction

    function automatic bit model_ready(input int m);
        return ren_m[m] && (n_m[m] < DEPTH || pop_pending(m));
    endfunction

    function automatic bit all_idle();
        for (int m = 0; m < NM; m++)
            if (active_m[m] || n_m[m] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        for (int m = 0; m < NM; m++) begin
            if (rst) begin
                n_m[m] = 0; rd_m[m] = 0; pos_m[m] = 0;
                active_m[m] = 1'b0; ren_m[m] = 1'b0; acc_m[m] = 1'b0;
            end else begin
                bit acc;
                bit popnow;
                acc    = tx_valid && model_ready(m);
                popnow = pop_pending(m);
                if (active_m[m] && pos_m[m] < flen(m) - 1) begin
                    pos_m[m]++;
                end else if (popnow) begin
                    cur_m[m]    = mem_m[m][rd_m[m]];
                    rd_m[m]     = (rd_m[m] + 1) % DEPTH;
                    n_m[m]--;
                    active_m[m] = 1'b1;
                    pos_m[m]    = 0;
                end else begin
                    active_m[m] = 1'b0;
                end
                if (acc) begin
                    mem_m[m][(rd_m[m] + n_m[m]) % DEPTH] = tx_data;
                    n_m[m]++;
                end
                acc_m[m] = acc;
                ren_m[m] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input int m, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d observed %0h expected %0h", tag, m, cycle, got, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < NM; m++) begin
            logic exp_txd;
            exp_txd = active_m[m] ? frame_level(m, cur_m[m], pos_m[m] / CPB) : 1'b1;
            chk("txd",   m, {7'b0, txd_w[m]},   {7'b0, exp_txd});
            chk("ready", m, {7'b0, ready_w[m]}, {7'b0, model_ready(m)});
            chk("busy",  m, {7'b0, busy_w[m]},  {7'b0, (active_m[m] || n_m[m] != 0)});
            chk("count", m, {5'b0, count_w[m]}, 8'(n_m[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cycle++;
        check_all();
    endtask

    // Hold a byte on the bus until the 8N1 instance accepts it
    task automatic push_hold(input logic [7:0] b);
        int waited;
        tx_data  = b;
        tx_valid = 1'b1;
        waited   = 0;
        do begin
            tick();
            waited++;
        end while (!acc_m[0] && waited < 2000);
        chk("push_timeout", 0, {7'b0, acc_m[0]}, 8'd1);
        $display("push 0x%02h accepted at cycle %0d", b, cycle);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int waited;
        waited = 0;
        while (!all_idle() && waited < limit) begin
            tick();
            waited++;
        end
        chk("idle_timeout", 0, {7'b0, all_idle()}, 8'd1);
        repeat (4) tick();
    endtask

    initial begin
        int waited;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Single byte, alternating pattern
        push_hold(8'h55);
        wait_idle(400);

        // Burst of six: FIFO fills, sixth byte enters on a pop edge
        for (int b = 1; b <= 6; b++) push_hold(8'(b));
        wait_idle(3000);

        // Parity and back-to-back frames
        push_hold(8'h07);
        push_hold(8'hA3);
        push_hold(8'h3C);
        wait_idle(1500);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            tick();
            if (acc_m[0]) $display("push 0x%02h accepted at cycle %0d", tx_data, cycle);
        end
        tx_valid = 1'b0;
        wait_idle(3000);

        // Reset during data bit 3 of the first frame
        push_hold(8'hFF);
        push_hold(8'h00);
        waited = 0;
        while (!(active_m[0] && pos_m[0] / CPB == 4) && waited < 400) begin
            tick();
            waited++;
        end
        chk("reach_bit3", 0, {7'b0, (active_m[0] && pos_m[0] / CPB == 4)}, 8'd1);
        #2 rst = 1'b1;
        #1;
        for (int m = 0; m < NM; m++) begin
            chk("rst_txd",   m, {7'b0, txd_w[m]},   8'd1);
            chk("rst_count", m, {5'b0, count_w[m]}, 8'd0);
            chk("rst_ready", m, {7'b0, ready_w[m]}, 8'd0);
            chk("rst_busy",  m, {7'b0, busy_w[m]},  8'd0);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (400) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
